mem_copy_initiator: RTL and testbench
=====================================

Name: mem_copy_initiator

Overview:
Bus initiator for the CPU-side data/IO address space, i.e. the master that drives the load/store interface of the data memory and IO block.
- Copies a block of 32-bit words from a source address to a destination address, one word at a time.
- Each word is a read transaction followed by a write transaction.
- Typical uses: moving in_port samples into data RAM, or RAM contents to out_port registers, without CPU loads and stores.
- Sits beside the CPU and is arbitrated externally. It owns the bus only while busy=1.

Parameters:
CNT_W, 8, width of the word-count input and progress counter
ADDR_STEP, 4, byte increment applied to both addresses after each word

Ports:
clock  input  1  system clock; the only clock in the block
resetn  input  1  synchronous, active-low reset
start  input  1  one-cycle request; sampled only in IDLE
src_addr  input  32  source byte address; bits [1:0] are ignored (forced 0)
dst_addr  input  32  destination byte address; bits [1:0] are ignored (forced 0)
count  input  CNT_W  number of words to copy
abort  input  1  stop request; level-sampled each cycle while busy
addr  output  32  bus address to the memory/IO responder
datain  output  32  bus write data to the responder
we  output  1  bus write enable
dataout  input  32  bus read data from the responder; valid in the same cycle addr is driven
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle completion pulse
aborted  output  1  status of the last transfer: 1 = ended by abort; held until the next start
words_done  output  CNT_W  number of words written in the current or last transfer

Behaviour:
- Reset (resetn=0 at a rising clock edge) has priority over every other input:
  - state=IDLE.
  - addr=0, datain=0, we=0.
  - busy=0, done=0, aborted=0, words_done=0.
  - Internal source/destination pointers and remaining-count register cleared.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - we=0, addr=0.
  - On start=1, latch src_ptr={src_addr[31:2],2'b00}, dst_ptr={dst_addr[31:2],2'b00}, rem=count.
  - Also clear words_done and aborted.
  - count=0: go to FIN (zero-length transfer; no bus activity).
  - count>0: go to RD.
- RD (one cycle):
  - Drive addr=src_ptr, we=0.
  - At the clock edge, capture dataout into the data register; src_ptr += ADDR_STEP.
  - Go to WR.
  - If abort=1 in this cycle: discard the captured data, set aborted=1, go to FIN. No write is issued.
- WR (one cycle):
  - Drive addr=dst_ptr, datain=captured data, we=1.
  - At the clock edge: dst_ptr += ADDR_STEP, words_done += 1, rem -= 1.
  - If rem becomes 0 or abort=1: go to FIN. An abort here lets the in-flight write complete and sets aborted=1.
  - Otherwise go to RD.
- FIN (one cycle):
  - done=1, we=0.
  - busy drops to 0 in this same cycle.
  - Go to IDLE.
- Combinational outputs: busy=1 in RD and WR only; done=1 in FIN only.
- Throughput and latency:
  - 2 cycles per word.
  - done is asserted 2*count+1 cycles after the start edge.
  - A zero-length transfer asserts done 1 cycle after the start edge.
- Address arithmetic: 32-bit modulo. 0xFFFFFFFC + 4 wraps to 0x00000000 with no error.
- Bus rules:
  - we is never high outside WR.
  - The address is stable for the whole RD/WR cycle. The responder's negative-phase write strobe therefore sees a settled addr, datain and we.
- start while busy or in FIN: ignored; no queueing.
- abort in IDLE: ignored.
- abort and the final WR in the same cycle: go to FIN with aborted=1 and words_done=count.
- Overlapping ranges: no hazard detection. Copying is strictly ascending word by word.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RD, WR, FIN);
  - ADDR_STEP;
  - the word-alignment mask constant 32'hFFFF_FFFC.
- One natural sub-module, mem_copy_ptr: a loadable 32-bit word pointer with an increment enable. Instantiate it twice, once for src and once for dst.

Test Plan:
- Reset: resetn=0 mid-WR with we=1 -> next cycle we=0, busy=0, addr=0, words_done=0, state IDLE.
- Basic copy: preload RAM words 0x00..0x0C with 0x11,0x22,0x33,0x44; start with src=0x00, dst=0x40, count=4 -> writes at 0x40,0x44,0x48,0x4C carry 0x11..0x44; done 9 cycles after start; words_done=4; aborted=0.
- IO path: in_port0=0xA5A5_0001, src=0x80, dst=0x10, count=1 -> RAM[0x10]=0xA5A5_0001. Then src=0x10, dst=0xC0, count=1 -> out_port0=0xA5A5_0001.
- Zero length: count=0 -> we never asserted; done 1 cycle after start; words_done=0.
- Abort: count=5, abort in the 3rd RD -> exactly 2 writes; done next cycle; aborted=1; words_done=2. Abort in the 2nd WR -> 2 writes, aborted=1.
- Alignment and wrap: src=0xFFFF_FFFE, count=2 -> reads at 0xFFFF_FFFC then 0x0000_0000. A start pulse while busy is ignored (the transfer completes unchanged).

Source files
------------

// File: rtl/mem_copy_initiator_pkg.sv
// Shared types and constants for the memory-copy bus initiator.
package mem_copy_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam int unsigned ADDR_STEP = 4;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/mem_copy_initiator_if.sv
// Load/store bus between the copy initiator and the data memory / IO responder.
interface mem_copy_initiator_if;
  logic [31:0] addr;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        we;

  modport master (output addr, output datain, output we, input dataout);
  modport slave  (input addr, input datain, input we, output dataout);
endinterface

// File: rtl/mem_copy_ptr.sv
// Loadable word pointer: load forces word alignment, inc adds STEP (32-bit modulo).
module mem_copy_ptr
  import mem_copy_initiator_pkg::*;
#(
  parameter int unsigned STEP = mem_copy_initiator_pkg::ADDR_STEP
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        load_i,
  input  logic        inc_i,
  input  logic [31:0] load_val_i,
  output logic [31:0] ptr_o
);

  logic [31:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = word_align(load_val_i);
    end else if (inc_i) begin
      ptr_d = ptr_q + 32'(STEP);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/mem_copy_initiator.sv
// Block-copy bus initiator: one read then one write per 32-bit word, abortable.
module mem_copy_initiator
  import mem_copy_initiator_pkg::*;
#(
  parameter int          CNT_W     = 8,
  parameter int unsigned ADDR_STEP = mem_copy_initiator_pkg::ADDR_STEP
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [CNT_W-1:0]     count,
  input  logic                 abort,
  mem_copy_initiator_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [CNT_W-1:0]     words_done
);

  state_e            state_q, state_d;
  logic [31:0]       data_q, data_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  wd_q, wd_d;
  logic              ab_q, ab_d;
  logic [31:0]       src_ptr, dst_ptr;
  logic              accept;

  assign accept = (state_q == ST_IDLE) && start;

  mem_copy_ptr #(.STEP(ADDR_STEP)) u_src_ptr (
    .clock      (clock),
    .resetn     (resetn),
    .load_i     (accept),
    .inc_i      (state_q == ST_RD),
    .load_val_i (src_addr),
    .ptr_o      (src_ptr)
  );

  mem_copy_ptr #(.STEP(ADDR_STEP)) u_dst_ptr (
    .clock      (clock),
    .resetn     (resetn),
    .load_i     (accept),
    .inc_i      (state_q == ST_WR),
    .load_val_i (dst_addr),
    .ptr_o      (dst_ptr)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      wd_q    <= '0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      wd_q    <= wd_d;
      ab_q    <= ab_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (count == '0) ? ST_FIN : ST_RD;
      ST_RD:   state_d = abort ? ST_FIN : ST_WR;
      ST_WR:   state_d = (abort || rem_q == CNT_W'(1)) ? ST_FIN : ST_RD;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // An abort during RD drops the read word so nothing stale reaches datain later.
  always_comb begin
    data_d = data_q;
    rem_d  = rem_q;
    wd_d   = wd_q;
    ab_d   = ab_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d = count;
          wd_d  = '0;
          ab_d  = 1'b0;
        end
      end
      ST_RD: begin
        if (abort) ab_d = 1'b1;
        else       data_d = bus.dataout;
      end
      ST_WR: begin
        rem_d = rem_q - CNT_W'(1);
        wd_d  = wd_q + CNT_W'(1);
        if (abort) ab_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.addr   = '0;
    bus.we     = 1'b0;
    bus.datain = data_q;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_RD: begin
        bus.addr = src_ptr;
        busy     = 1'b1;
      end
      ST_WR: begin
        bus.addr = dst_ptr;
        bus.we   = 1'b1;
        busy     = 1'b1;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  assign aborted    = ab_q;
  assign words_done = wd_q;

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Randomized scoreboard bench for mem_copy_initiator with a word-addressed responder.
module tb_mem_copy_initiator;

  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             resetn;
  logic             start;
  logic [31:0]      src_addr, dst_addr;
  logic [CNT_W-1:0] count;
  logic             abort;
  logic             busy, done, aborted;
  logic [CNT_W-1:0] words_done;

  mem_copy_initiator_if bus ();

  mem_copy_initiator #(.CNT_W(CNT_W), .ADDR_STEP(4)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .count      (count),
    .abort      (abort),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .words_done (words_done)
  );

  always #5 clock = ~clock;

  // Responder memory: 1024 words, aliased every 4 KiB.
  logic [31:0] mem     [1024];
  logic [31:0] img     [1024];
  logic [31:0] model_mem [1024];
  logic        load_req = 1'b0;

  assign bus.dataout = mem[bus.addr[11:2]];

  always @(negedge clock) begin
    if (load_req) begin
      for (int i = 0; i < 1024; i++) mem[i] <= img[i];
    end else if (bus.we) begin
      mem[bus.addr[11:2]] <= bus.datain;
    end
  end

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct { int wd; bit ab; int lat; int bc; } dn_t;

  wr_t         wq[$];
  logic [31:0] rq[$];
  dn_t         dq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int busy_cnt = 0;
  bit mon_en   = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops scoreboard entries whenever the bus or status shows activity.
  always @(negedge clock) begin
    if (resetn && mon_en) begin
      if (bus.we) begin
        chk("we_only_when_busy", {31'd0, busy}, 32'd1);
        if (wq.size() == 0) begin
          chk("unexpected_write_addr", bus.addr, 32'hDEAD_BEEF);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("write_addr", bus.addr, w.a);
          chk("write_data", bus.datain, w.d);
        end
      end
      if (busy && !bus.we) begin
        if (rq.size() == 0) begin
          chk("unexpected_read_addr", bus.addr, 32'hDEAD_BEEF);
        end else begin
          logic [31:0] ra;
          ra = rq.pop_front();
          chk("read_addr", bus.addr, ra);
        end
      end
      if (busy) busy_cnt++;
      if (done) begin
        chk("done_not_busy", {31'd0, busy}, 32'd0);
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          dn_t e;
          e = dq.pop_front();
          chk("words_done", 32'(words_done), 32'(e.wd));
          chk("aborted", {31'd0, aborted}, {31'd0, e.ab});
          chk("done_latency", 32'(cyc - acc_cyc + 1), 32'(e.lat));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.bc));
        end
        busy_cnt = 0;
      end
    end
  end

  // Transaction-level model: abort_at is the cycle index (0 = first RD) carrying abort, -1 = none.
  task automatic xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                      input int abort_at, input bit glitch);
    int n_rd, n_wr, bc, j;
    bit ab;
    logic [31:0] sa, da, v;
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    if (n == 0) begin
      n_rd = 0; n_wr = 0; bc = 0; ab = 0;
    end else if (abort_at < 0 || abort_at >= 2 * n) begin
      n_rd = n; n_wr = n; bc = 2 * n; ab = 0;
    end else begin
      n_rd = abort_at / 2 + 1;
      n_wr = (abort_at % 2 == 0) ? abort_at / 2 : abort_at / 2 + 1;
      bc   = abort_at + 1;
      ab   = 1;
    end
    for (int i = 0; i < n_rd; i++) rq.push_back(sa + 32'(4 * i));
    for (int i = 0; i < n_wr; i++) begin
      logic [31:0] ra, wa;
      ra = sa + 32'(4 * i);
      wa = da + 32'(4 * i);
      v  = model_mem[ra[11:2]];
      model_mem[wa[11:2]] = v;
      wq.push_back('{a: wa, d: v});
    end
    dq.push_back('{wd: n_wr, ab: ab, lat: bc + 1, bc: bc});

    @(posedge clock); #1;
    start = 1'b1; src_addr = s; dst_addr = d; count = CNT_W'(n);
    @(posedge clock); #1;
    acc_cyc = cyc;
    start   = 1'b0;
    j = 0;
    while (!done && j < 2 * n + 4) begin
      abort = (j == abort_at);
      if (glitch && j == 1) begin
        start = 1'b1; src_addr = $urandom; dst_addr = $urandom; count = CNT_W'($urandom_range(1, 9));
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      j++;
    end
    abort = 1'b0;
    start = 1'b0;
    chk("done_within_budget", {31'd0, done}, 32'd1);
    @(posedge clock); #1;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; count = '0;
    for (int i = 0; i < 1024; i++) img[i] = $urandom;
    img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33; img[3] = 32'h44;
    img[32] = 32'hA5A5_0001;
    for (int i = 0; i < 1024; i++) model_mem[i] = img[i];
    load_req = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    load_req = 1'b0;
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_datain", bus.datain, 32'd0);
    chk("rst_we", {31'd0, bus.we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_aborted", {31'd0, aborted}, 32'd0);
    chk("rst_words_done", 32'(words_done), 32'd0);
    resetn = 1'b1;
    mon_en = 1'b1;

    xfer(32'h00, 32'h40, 4, -1, 0);
    xfer(32'h80, 32'h10, 1, -1, 0);
    xfer(32'h10, 32'hC0, 1, -1, 0);
    chk("io_out_port0", mem[48], 32'hA5A5_0001);
    xfer(32'h200, 32'h240, 0, -1, 0);
    xfer(32'h200, 32'h280, 5, 4, 0);
    xfer(32'h300, 32'h380, 5, 3, 0);
    xfer(32'h300, 32'h3C0, 3, 5, 0);
    xfer(32'hFFFF_FFFE, 32'h800, 2, -1, 0);
    xfer(32'h100, 32'h180, 3, -1, 1);

    for (int t = 0; t < 20; t++) begin
      int n, ab_at;
      n     = $urandom_range(0, 8);
      ab_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2 * n + 1) : -1;
      xfer($urandom_range(0, 4095), $urandom_range(0, 4095), n, ab_at, $urandom_range(0, 1) == 1);
    end

    // Reset while a write is on the bus.
    mon_en = 1'b0;
    @(posedge clock); #1;
    start = 1'b1; src_addr = 32'h600; dst_addr = 32'h700; count = CNT_W'(4);
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    chk("pre_reset_we", {31'd0, bus.we}, 32'd1);
    resetn = 1'b0;
    @(posedge clock); #1;
    chk("midwr_rst_we", {31'd0, bus.we}, 32'd0);
    chk("midwr_rst_busy", {31'd0, busy}, 32'd0);
    chk("midwr_rst_addr", bus.addr, 32'd0);
    chk("midwr_rst_words_done", 32'(words_done), 32'd0);
    chk("midwr_rst_done", {31'd0, done}, 32'd0);
    resetn = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 1024; i++) model_mem[i] = mem[i];
    wq.delete(); rq.delete(); dq.delete();
    busy_cnt = 0;
    mon_en = 1'b1;

    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(1, 8);
      xfer($urandom_range(0, 4095), $urandom_range(0, 4095), n, -1, 0);
    end

    repeat (2) @(posedge clock);
    #1;
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
